// File: rtl/delay_chain_monitor_if.sv
// Handshake/result bundle between the far-end chain monitor and its driver.
// The master drives the launch strobe and chain sample; the slave reports the measurement.
interface delay_chain_monitor_if #(
  parameter int CW = 9
);
  logic          launch;
  logic          chain_out;
  logic          clear;
  logic [CW-1:0] latency;
  logic [CW-1:0] pulse_width;
  logic          done;
  logic          timeout;
  logic          overrun;
  logic          busy;

  modport master (
    output launch, chain_out, clear,
    input  latency, pulse_width, done, timeout, overrun, busy
  );

  modport slave (
    input  launch, chain_out, clear,
    output latency, pulse_width, done, timeout, overrun, busy
  );
endinterface

// File: rtl/delay_chain_monitor.sv
// Far-end receiver of the shift-register delay chain: measures launch-to-output latency and
// pulse width, flagging missing pulses (timeout) and relaunch while a measurement is pending.
module delay_chain_monitor #(
  parameter int CW      = 9,
  parameter int TIMEOUT = 300
) (
  input  logic                  clk,
  input  logic                  rst_n,
  delay_chain_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_prev;
  logic [CW-1:0] r_latency;
  logic [CW-1:0] r_width;
  logic          r_done;
  logic          r_timeout;
  logic          r_overrun;
  logic          w_rise;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // A level already high at launch must fall and rise again to count as an arrival.
  assign w_rise = bus.chain_out & ~r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_prev    <= 1'b0;
      r_latency <= '0;
      r_width   <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_prev <= bus.chain_out;
      if (bus.clear) begin
        r_state   <= S_IDLE;
        r_latency <= '0;
        r_width   <= '0;
        r_done    <= 1'b0;
        r_timeout <= 1'b0;
        r_overrun <= 1'b0;
      end else if (bus.launch) begin
        if (r_state == S_ARMED || r_state == S_MEASURE) begin
          r_overrun <= 1'b1;
        end
        r_state   <= S_ARMED;
        r_cnt     <= CW'(1);
        r_done    <= 1'b0;
        r_timeout <= 1'b0;
        r_latency <= '0;
        r_width   <= '0;
      end else begin
        case (r_state)
          S_ARMED: begin
            if (w_rise) begin
              r_latency <= r_cnt;
              r_width   <= CW'(1);
              r_state   <= S_MEASURE;
            end else if (r_cnt == TO_V) begin
              r_timeout <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_MEASURE: begin
            if (bus.chain_out) begin
              r_width <= sat_inc(r_width);
              // A pulse that never falls is reported as a timeout; latency stays valid.
              if (r_width == TO_V) begin
                r_timeout <= 1'b1;
                r_state   <= S_IDLE;
              end
            end else begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.latency     = r_latency;
  assign bus.pulse_width = r_width;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.overrun     = r_overrun;
  assign bus.busy        = (r_state == S_ARMED) || (r_state == S_MEASURE);

endmodule
